// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache miss controller: FSM state encoding,
// width helpers and block-base address masking.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_FETCH     = 3'd3,
    ST_FILL      = 3'd4,
    ST_ACCESS    = 3'd5,
    ST_RESPOND   = 3'd6
  } ctrl_state_e;

  // A direct-mapped cache still needs a one-bit way field on the ports.
  function automatic int way_width(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

  function automatic int offset_width(input int block_size);
    return $clog2(block_size);
  endfunction

  function automatic logic [63:0] block_base(input logic [63:0] addr, input int offset_w);
    return addr & ~((64'd1 << offset_w) - 64'd1);
  endfunction

endpackage

// File: rtl/cache_wait_timer.sv
// Wait-cycle counter for memory handshakes; flags the cycle in which the
// count reaches all-ones so the controller can abandon the wait.
module cache_wait_timer #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;
  localparam logic [WIDTH-1:0] LAST_WAIT = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != MAX_COUNT)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Asserted in the waiting cycle whose increment lands on all-ones.
  assign expire = enable && !clear && (count_reg == LAST_WAIT);

endmodule

// File: rtl/cache_miss_controller.sv
// Sequencing FSM for one cache access: lookup, optional dirty write-back,
// block fetch and fill, data access and completion pulse to the CPU.
module cache_miss_controller
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_SIZE    = 32,
  parameter int NUM_WAYS      = 4,
  parameter int COUNTER_WIDTH = 8,
  localparam int OFFSET_W     = offset_width(BLOCK_SIZE),
  localparam int WAY_W        = way_width(NUM_WAYS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     request,
  input  logic                     read,
  input  logic                     write,
  input  logic [ADDRESS_WIDTH-1:0] cpuRequestAddress,
  output logic                     lookupEn,
  input  logic                     lookupHit,
  input  logic [WAY_W-1:0]         hitWay,
  input  logic [WAY_W-1:0]         victimWay,
  input  logic                     victimDirty,
  input  logic [ADDRESS_WIDTH-1:0] victimAddress,
  output logic                     writeBackReq,
  output logic [ADDRESS_WIDTH-1:0] writeBackAddress,
  input  logic                     writeBackAck,
  output logic                     fetchReq,
  output logic [ADDRESS_WIDTH-1:0] fetch_address,
  input  logic                     fetchValid,
  output logic                     fillEn,
  output logic [WAY_W-1:0]         fillWay,
  output logic [WAY_W-1:0]         accessWay,
  output logic                     accessEn,
  output logic                     accessWrite,
  output logic                     readyToSend,
  output logic                     error,
  output logic                     busy
);

  ctrl_state_e              state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0] addr_reg;
  logic [ADDRESS_WIDTH-1:0] wb_addr_reg;
  logic [WAY_W-1:0]         way_reg;
  logic                     write_reg;
  logic                     error_reg;
  logic                     accept;
  logic                     timeout;
  logic                     timer_clear;
  logic                     timer_enable;
  logic                     timer_expire;

  assign accept = request && (read ^ write);

  always_comb begin
    state_next = state_reg;
    timeout    = 1'b0;
    case (state_reg)
      ST_IDLE:   if (accept) state_next = ST_LOOKUP;
      ST_LOOKUP: begin
        if (lookupHit)        state_next = ST_ACCESS;
        else if (victimDirty) state_next = ST_WRITEBACK;
        else                  state_next = ST_FETCH;
      end
      // A handshake arriving in the expiring cycle takes priority over timeout.
      ST_WRITEBACK: begin
        if (writeBackAck) begin
          state_next = ST_FETCH;
        end else if (timer_expire) begin
          state_next = ST_RESPOND;
          timeout    = 1'b1;
        end
      end
      ST_FETCH: begin
        if (fetchValid) begin
          state_next = ST_FILL;
        end else if (timer_expire) begin
          state_next = ST_RESPOND;
          timeout    = 1'b1;
        end
      end
      ST_FILL:    state_next = ST_ACCESS;
      ST_ACCESS:  state_next = ST_RESPOND;
      ST_RESPOND: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  assign timer_enable = (state_reg == ST_WRITEBACK) || (state_reg == ST_FETCH);
  assign timer_clear  = ((state_next == ST_WRITEBACK) || (state_next == ST_FETCH)) &&
                        (state_next != state_reg);

  cache_wait_timer #(
    .WIDTH (COUNTER_WIDTH)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      wb_addr_reg <= '0;
      way_reg     <= '0;
      write_reg   <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            addr_reg  <= cpuRequestAddress;
            write_reg <= write;
            error_reg <= 1'b0;
          end
        end
        ST_LOOKUP: begin
          if (lookupHit) begin
            way_reg <= hitWay;
          end else begin
            way_reg     <= victimWay;
            wb_addr_reg <= ADDRESS_WIDTH'(block_base(64'(victimAddress), OFFSET_W));
          end
        end
        ST_WRITEBACK, ST_FETCH: begin
          if (timeout) error_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Strobes decode the state register so reset removes them without a clock.
  assign lookupEn         = (state_reg == ST_LOOKUP);
  assign writeBackReq     = (state_reg == ST_WRITEBACK);
  assign fetchReq         = (state_reg == ST_FETCH);
  assign fillEn           = (state_reg == ST_FILL);
  assign accessEn         = (state_reg == ST_ACCESS);
  assign readyToSend      = (state_reg == ST_RESPOND);
  assign error            = (state_reg == ST_RESPOND) && error_reg;
  assign busy             = (state_reg != ST_IDLE);
  assign writeBackAddress = wb_addr_reg;
  assign fetch_address    = ADDRESS_WIDTH'(block_base(64'(addr_reg), OFFSET_W));
  assign fillWay          = way_reg;
  assign accessWay        = way_reg;
  assign accessWrite      = write_reg;

endmodule

// File: tb/tb_cache_miss_controller.sv
// Directed bench for cache_miss_controller: hit, clean/dirty miss, timeout,
// ignored requests and asynchronous reset, with cycle-exact expectations.
module tb_cache_miss_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        request = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] cpuRequestAddress = '0;
  logic        lookupEn;
  logic        lookupHit = 1'b0;
  logic [1:0]  hitWay = '0;
  logic [1:0]  victimWay = '0;
  logic        victimDirty = 1'b0;
  logic [31:0] victimAddress = '0;
  logic        writeBackReq;
  logic [31:0] writeBackAddress;
  logic        writeBackAck = 1'b0;
  logic        fetchReq;
  logic [31:0] fetch_address;
  logic        fetchValid = 1'b0;
  logic        fillEn;
  logic [1:0]  fillWay;
  logic [1:0]  accessWay;
  logic        accessEn;
  logic        accessWrite;
  logic        readyToSend;
  logic        error;
  logic        busy;

  int check_count = 0;
  int error_count = 0;

  int          wb_first, fetch_first, wb_cnt, fetch_cnt, fill_cyc, access_cyc, rts_cyc;
  logic [31:0] wb_addr_obs, fetch_addr_obs;
  logic [1:0]  fill_way_obs, access_way_obs;
  logic        err_obs, access_wr_obs;

  always #5 clk = ~clk;

  cache_miss_controller #(
    .ADDRESS_WIDTH (32),
    .BLOCK_SIZE    (32),
    .NUM_WAYS      (4),
    .COUNTER_WIDTH (4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .request           (request),
    .read              (read),
    .write             (write),
    .cpuRequestAddress (cpuRequestAddress),
    .lookupEn          (lookupEn),
    .lookupHit         (lookupHit),
    .hitWay            (hitWay),
    .victimWay         (victimWay),
    .victimDirty       (victimDirty),
    .victimAddress     (victimAddress),
    .writeBackReq      (writeBackReq),
    .writeBackAddress  (writeBackAddress),
    .writeBackAck      (writeBackAck),
    .fetchReq          (fetchReq),
    .fetch_address     (fetch_address),
    .fetchValid        (fetchValid),
    .fillEn            (fillEn),
    .fillWay           (fillWay),
    .accessWay         (accessWay),
    .accessEn          (accessEn),
    .accessWrite       (accessWrite),
    .readyToSend       (readyToSend),
    .error             (error),
    .busy              (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One CPU access; the bench acts as tag array and memory. Cycle 0 is the
  // request cycle. b_wait/f_wait give the handshake cycle (0 = never).
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic hit,
                         input logic [1:0] hway, input logic [1:0] vway, input logic vdirty,
                         input logic [31:0] vaddr, input int b_wait, input int f_wait,
                         input int inj_cyc);
    wb_first = -1; fetch_first = -1; wb_cnt = 0; fetch_cnt = 0;
    fill_cyc = -1; access_cyc = -1; rts_cyc = -1;
    wb_addr_obs = '0; fetch_addr_obs = '0; fill_way_obs = '0; access_way_obs = '0;
    err_obs = 1'b0; access_wr_obs = 1'b0;
    @(negedge clk);
    request = 1'b1; read = ~wr; write = wr; cpuRequestAddress = addr;
    lookupHit = hit; hitWay = hway; victimWay = vway; victimDirty = vdirty; victimAddress = vaddr;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == inj_cyc) begin
        request = 1'b1; read = 1'b1; write = 1'b0; cpuRequestAddress = 32'h0000_5000;
      end else begin
        request = 1'b0;
      end
      if (writeBackReq) begin
        wb_cnt++;
        if (wb_first < 0) wb_first = k;
        wb_addr_obs = writeBackAddress;
      end
      writeBackAck = writeBackReq && (wb_cnt == b_wait);
      if (fetchReq) begin
        fetch_cnt++;
        if (fetch_first < 0) fetch_first = k;
        fetch_addr_obs = fetch_address;
      end
      fetchValid = fetchReq && (fetch_cnt == f_wait);
      if (fillEn) begin
        fill_cyc = k; fill_way_obs = fillWay;
      end
      if (accessEn) begin
        access_cyc = k; access_way_obs = accessWay; access_wr_obs = accessWrite;
      end
      if (readyToSend) begin
        rts_cyc = k; err_obs = error;
        break;
      end
    end
    writeBackAck = 1'b0;
    fetchValid = 1'b0;
    request = 1'b0;
    $display("txn addr=0x%08h wr=%0b hit=%0b dirty=%0b wb_first=%0d fetch_first=%0d fill=%0d access=%0d rts=%0d err=%0b",
             addr, wr, hit, vdirty, wb_first, fetch_first, fill_cyc, access_cyc, rts_cyc, err_obs);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check_eq(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    // Reset values while rst_n is held low.
    #3;
    check_eq("reset_strobes",
             64'({lookupEn, writeBackReq, fetchReq, fillEn, accessEn, accessWrite, readyToSend, error, busy}),
             64'd0);
    check_eq("reset_addrs", {writeBackAddress, fetch_address}, 64'd0);
    check_eq("reset_ways", 64'({fillWay, accessWay}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_after_reset", 64'(busy), 64'd0);

    // Read hit.
    run_txn(32'h0000_1044, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 32'h0, 0, 0, -1);
    check_eq("hit_access_cyc", 64'(access_cyc), 64'd2);
    check_eq("hit_access_way", 64'(access_way_obs), 64'd2);
    check_eq("hit_rts_cyc", 64'(rts_cyc), 64'd3);
    check_eq("hit_no_mem", 64'({wb_cnt[7:0], fetch_cnt[7:0]}), 64'd0);
    check_eq("hit_no_error", 64'(err_obs), 64'd0);
    check_idle("hit_idle");

    // Clean miss, fetch valid in 5th FETCH cycle.
    run_txn(32'h0000_2047, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 32'h0, 0, 5, -1);
    check_eq("clean_fetch_first", 64'(fetch_first), 64'd2);
    check_eq("clean_fetch_addr", 64'(fetch_addr_obs), 64'h2040);
    check_eq("clean_fill_cyc", 64'(fill_cyc), 64'd7);
    check_eq("clean_fill_way", 64'(fill_way_obs), 64'd1);
    check_eq("clean_access_way", 64'(access_way_obs), 64'd1);
    check_eq("clean_rts_cyc", 64'(rts_cyc), 64'd9);
    check_eq("clean_no_wb", 64'(wb_cnt), 64'd0);
    check_idle("clean_idle");

    // Dirty write miss: ack in 3rd WRITEBACK cycle, valid in 2nd FETCH cycle.
    run_txn(32'h0000_4123, 1'b1, 1'b0, 2'd0, 2'd3, 1'b1, 32'h0000_8000, 3, 2, -1);
    check_eq("dirty_wb_first", 64'(wb_first), 64'd2);
    check_eq("dirty_wb_addr", 64'(wb_addr_obs), 64'h8000);
    check_eq("dirty_fetch_first", 64'(fetch_first), 64'd5);
    check_eq("dirty_fetch_addr", 64'(fetch_addr_obs), 64'h4120);
    check_eq("dirty_access_wr", 64'(access_wr_obs), 64'd1);
    check_eq("dirty_rts_cyc", 64'(rts_cyc), 64'd9);
    check_idle("dirty_idle");

    // Fetch never answered: 15 FETCH cycles then error with readyToSend.
    run_txn(32'h0000_6000, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 32'h0, 0, 0, -1);
    check_eq("tmo_fetch_cnt", 64'(fetch_cnt), 64'd15);
    check_eq("tmo_rts_cyc", 64'(rts_cyc), 64'd17);
    check_eq("tmo_error", 64'(err_obs), 64'd1);
    check_eq("tmo_no_fill", 64'(fill_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    check_idle("tmo_idle");

    // Valid in the saturating cycle wins over the timeout.
    run_txn(32'h0000_6000, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 32'h0, 0, 15, -1);
    check_eq("sat_fill_cyc", 64'(fill_cyc), 64'd17);
    check_eq("sat_rts_cyc", 64'(rts_cyc), 64'd19);
    check_eq("sat_no_error", 64'(err_obs), 64'd0);
    check_idle("sat_idle");

    // Malformed request (read and write both high) is ignored.
    @(negedge clk);
    request = 1'b1; read = 1'b1; write = 1'b1; cpuRequestAddress = 32'h0000_7000;
    repeat (3) @(negedge clk);
    check_eq("malformed_busy", 64'({busy, lookupEn}), 64'd0);
    request = 1'b0; read = 1'b0; write = 1'b0;
    $display("txn malformed read=write=1 busy=%0b", busy);

    // New request during FETCH must not disturb the latched address.
    run_txn(32'h0000_3010, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 32'h0, 0, 4, 3);
    check_eq("inject_fetch_addr", 64'(fetch_addr_obs), 64'h3000);
    check_eq("inject_rts_cyc", 64'(rts_cyc), 64'd8);
    check_idle("inject_idle");

    // Reset asserted during WRITEBACK.
    @(negedge clk);
    request = 1'b1; read = 1'b1; write = 1'b0; cpuRequestAddress = 32'h0000_9044;
    lookupHit = 1'b0; victimDirty = 1'b1; victimWay = 2'd3; victimAddress = 32'h0000_9000;
    @(negedge clk);
    request = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_wb_active", 64'(writeBackReq), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_strobes",
             64'({lookupEn, writeBackReq, fetchReq, fillEn, accessEn, accessWrite, readyToSend, error, busy}),
             64'd0);
    check_eq("rst_mid_addrs", {writeBackAddress, fetch_address}, 64'd0);
    check_eq("rst_mid_ways", 64'({fillWay, accessWay}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_release_idle", 64'({busy, writeBackReq}), 64'd0);
    $display("txn reset during writeback busy=%0b", busy);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
